// File: rtl/src_sink_pkg.sv
// Shared state encoding and default sizing for the source-to-sink arbiter.
package src_sink_pkg;

    localparam int DEF_N_SRC      = 2;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_BURST_MAX  = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Width needed to hold a beat count from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/src_sink_fifo.sv
// Circular buffer between the arbiter and the sink. A push while full is dropped,
// regardless of a simultaneous pop, so the arbiter must gate its ready on o_full.
module src_sink_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    // Stale entries are not cleared by reset, so mask the head while empty.
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/src_sink_arbiter.sv
// Round-robin arbiter that grants bursts of up to BURST_MAX beats from one of
// N_SRC sources into a FIFO feeding a single sink.
//   state    | meaning
//   ST_IDLE  | wait for enable and a valid source, pick next round-robin winner
//   ST_GRANT | stream beats from the granted source into the FIFO
//   ST_DRAIN | enable dropped during a grant; hold off grants until FIFO empties
module src_sink_arbiter
    import src_sink_pkg::*;
#(
    parameter int N_SRC      = DEF_N_SRC,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BURST_MAX  = DEF_BURST_MAX,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [N_SRC-1:0]         src_valid,
    input  logic [N_SRC*DATA_W-1:0]  src_data,
    output logic [N_SRC-1:0]         src_ready,
    output logic                     snk_valid,
    output logic [DATA_W-1:0]        snk_data,
    output logic [$clog2(N_SRC)-1:0] snk_src,
    input  logic                     snk_ready,
    output logic                     busy
);

    localparam int SRC_W = $clog2(N_SRC);
    localparam int CNT_W = cnt_width(BURST_MAX);
    localparam int ENT_W = SRC_W + DATA_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);
    localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(N_SRC - 1);

    state_t             r_state;
    logic [SRC_W-1:0]   r_grant;
    logic [SRC_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic [SRC_W-1:0]   w_pick;
    logic               w_any;
    logic [DATA_W-1:0]  w_grant_data;
    logic               w_grant_valid;
    logic [N_SRC-1:0]   w_ready_mask;
    logic               w_in_grant;
    logic               w_xfer;
    logic               w_grant_end;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic [ENT_W-1:0]   w_push_data;
    logic [ENT_W-1:0]   w_pop_data;

    // Search starts just after the previous winner so every source gets a turn.
    always_comb begin
        w_pick = r_last;
        w_any  = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!w_any && src_valid[(int'(r_last) + k) % N_SRC]) begin
                w_pick = SRC_W'((int'(r_last) + k) % N_SRC);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant_data  = '0;
        w_grant_valid = 1'b0;
        w_ready_mask  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_grant == SRC_W'(i)) begin
                w_grant_data    = src_data[i*DATA_W +: DATA_W];
                w_grant_valid   = src_valid[i];
                w_ready_mask[i] = 1'b1;
            end
        end
    end

    assign w_in_grant  = (r_state == ST_GRANT);
    assign src_ready   = (w_in_grant && !w_fifo_full) ? w_ready_mask : '0;
    assign w_xfer      = w_in_grant && w_grant_valid && !w_fifo_full;
    // A falling enable still lets this cycle's beat land before leaving GRANT.
    assign w_grant_end = w_in_grant &&
                         (!w_grant_valid || !enable ||
                          (w_xfer && (r_beat_cnt == LAST_BEAT)));
    assign w_push_data = {r_grant, w_grant_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_last     <= LAST_SRC;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_any) begin
                        r_grant <= w_pick;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                    if (w_grant_end) begin
                        r_last     <= r_grant;
                        r_beat_cnt <= '0;
                        r_state    <= enable ? ST_IDLE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_fifo_empty) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    src_sink_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_xfer),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign snk_valid           = !w_fifo_empty;
    assign w_pop               = snk_valid && snk_ready;
    assign {snk_src, snk_data} = w_pop_data;
    assign busy                = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_src_sink_arbiter.sv
// Scoreboard bench for src_sink_arbiter: directed source streams, expected sink
// beats queued up front and compared by an independent sink monitor.
module tb_src_sink_arbiter;

    localparam int N_SRC  = 2;
    localparam int DATA_W = 8;
    localparam int SRC_W  = 1;
    localparam int ENT_W  = SRC_W + DATA_W;

    logic                    clk       = 1'b0;
    logic                    rst       = 1'b1;
    logic                    enable    = 1'b0;
    logic                    snk_ready = 1'b0;
    logic [N_SRC-1:0]        src_valid = '0;
    logic [N_SRC*DATA_W-1:0] src_data  = '0;
    logic [N_SRC-1:0]        src_ready;
    logic                    snk_valid;
    logic [DATA_W-1:0]       snk_data;
    logic [SRC_W-1:0]        snk_src;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    logic [ENT_W-1:0]  sb_q[$];
    logic [DATA_W-1:0] src_q0[$];
    logic [DATA_W-1:0] src_q1[$];
    logic [N_SRC-1:0]  acc_flags = '0;
    int                acc0 = 0;
    int                acc1 = 0;
    logic [ENT_W-1:0]  mon_exp;

    src_sink_arbiter #(
        .N_SRC      (N_SRC),
        .DATA_W     (DATA_W),
        .BURST_MAX  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .snk_valid (snk_valid),
        .snk_data  (snk_data),
        .snk_src   (snk_src),
        .snk_ready (snk_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input int s, input int d);
        if (s == 0) src_q0.push_back(DATA_W'(d));
        else        src_q1.push_back(DATA_W'(d));
    endtask

    task automatic expect_beat(input int s, input int d);
        sb_q.push_back({SRC_W'(s), DATA_W'(d)});
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int done;
        done = 0;
        for (int i = 0; i < budget && done == 0; i++) begin
            cyc(1);
            if (!busy && src_q0.size() == 0 && src_q1.size() == 0 && sb_q.size() == 0)
                done = 1;
        end
        check(name, done, 1);
    endtask

    // Accepted beats are captured on the edge and retired from the source queues.
    always @(posedge clk) acc_flags <= src_valid & src_ready;

    always @(negedge clk) begin
        if (acc_flags[0] && src_q0.size() > 0) begin
            void'(src_q0.pop_front());
            acc0++;
        end
        if (acc_flags[1] && src_q1.size() > 0) begin
            void'(src_q1.pop_front());
            acc1++;
        end
        src_valid[0] = (src_q0.size() > 0);
        src_valid[1] = (src_q1.size() > 0);
        src_data[DATA_W-1:0]        = (src_q0.size() > 0) ? src_q0[0] : '0;
        src_data[2*DATA_W-1:DATA_W] = (src_q1.size() > 0) ? src_q1[0] : '0;
    end

    always @(negedge clk) begin
        #2;
        if (!rst && snk_valid && snk_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual src=%0d data=0x%0h required=none",
                         snk_src, snk_data);
            end else begin
                mon_exp = sb_q.pop_front();
                check("sink_src", snk_src, mon_exp[ENT_W-1 -: SRC_W]);
                check("sink_data", snk_data, mon_exp[DATA_W-1:0]);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int base;

        cyc(2);
        check("rst_src_ready", src_ready, 0);
        check("rst_snk_valid", snk_valid, 0);
        check("rst_snk_data", snk_data, 0);
        check("rst_snk_src", snk_src, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        enable = 1'b1;
        snk_ready = 1'b1;
        cyc(1);

        // Both sources streaming: bursts of 4 alternate 0,1,0,1.
        for (int i = 0; i < 8; i++) begin
            send(0, 8'h20 + i);
            send(1, 8'h30 + i);
        end
        for (int i = 0; i < 4; i++) expect_beat(0, 8'h20 + i);
        for (int i = 0; i < 4; i++) expect_beat(1, 8'h30 + i);
        for (int i = 4; i < 8; i++) expect_beat(0, 8'h20 + i);
        for (int i = 4; i < 8; i++) expect_beat(1, 8'h30 + i);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cyc(1);
            if (src_ready != 0) found = 1;
        end
        check("alt_first_grant", src_ready, 2'b01);
        cyc(1);
        check("lat_snk_valid", snk_valid, 1);
        check("lat_snk_data", snk_data, 8'h20);
        check("lat_snk_src", snk_src, 0);
        wait_quiet("alt_done", 100);

        // Single source, 6 beats: burst of 4, one idle cycle, regrant for the rest.
        base = acc0;
        for (int i = 0; i < 6; i++) begin
            send(0, 8'h10 + i);
            expect_beat(0, 8'h10 + i);
        end
        for (int i = 0; i < 40 && acc0 < base + 4; i++) cyc(1);
        check("burst_accepted", acc0 - base, 4);
        check("burst_end_gap", src_ready, 2'b00);
        cyc(1);
        check("regrant_src0", src_ready, 2'b01);
        wait_quiet("burst_done", 100);

        // Sink stalled: FIFO fills after 4 beats and the head is held.
        snk_ready = 1'b0;
        base = acc1;
        for (int i = 0; i < 6; i++) begin
            send(1, 8'h40 + i);
            expect_beat(1, 8'h40 + i);
        end
        cyc(15);
        check("full_accepted", acc1 - base, 4);
        check("full_ready_low", src_ready, 2'b00);
        check("full_snk_valid", snk_valid, 1);
        check("full_head_data", snk_data, 8'h40);
        check("full_head_src", snk_src, 1);
        cyc(3);
        check("full_hold_data", snk_data, 8'h40);
        check("full_busy", busy, 1);
        snk_ready = 1'b1;
        wait_quiet("full_done", 100);

        // Enable drops during a grant: the in-flight beat lands, then DRAIN.
        snk_ready = 1'b0;
        base = acc0;
        for (int i = 0; i < 4; i++) begin
            send(0, 8'h50 + i);
            expect_beat(0, 8'h50 + i);
        end
        for (int i = 0; i < 20 && acc0 < base + 1; i++) cyc(1);
        enable = 1'b0;
        cyc(1);
        check("drain_ready", src_ready, 2'b00);
        check("drain_busy", busy, 1);
        cyc(2);
        check("drain_two_beats", acc0 - base, 2);
        check("drain_ready_held", src_ready, 2'b00);
        check("drain_head", snk_data, 8'h50);
        snk_ready = 1'b1;
        cyc(1);
        check("drain_busy_pop1", busy, 1);
        cyc(1);
        check("drain_empty_valid", snk_valid, 0);
        check("drain_busy_pop2", busy, 1);
        cyc(1);
        check("drain_idle_busy", busy, 0);
        cyc(3);
        check("disabled_no_grant", src_ready, 2'b00);
        check("disabled_busy", busy, 0);
        enable = 1'b1;
        wait_quiet("drain_done", 100);

        // Reset with 3 beats buffered: they vanish and source 0 wins next.
        snk_ready = 1'b0;
        base = acc0;
        for (int i = 0; i < 3; i++) send(0, 8'h60 + i);
        for (int i = 0; i < 30 && acc0 < base + 3; i++) cyc(1);
        cyc(2);
        check("prerst_accepted", acc0 - base, 3);
        check("prerst_valid", snk_valid, 1);
        rst = 1'b1;
        #1;
        check("midrst_snk_valid", snk_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_src_ready", src_ready, 0);
        check("midrst_snk_data", snk_data, 0);
        cyc(1);
        rst = 1'b0;
        snk_ready = 1'b1;
        cyc(2);
        check("postrst_empty", snk_valid, 0);
        send(0, 8'h70);
        send(1, 8'h71);
        expect_beat(0, 8'h70);
        expect_beat(1, 8'h71);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cyc(1);
            if (src_ready != 0) found = 1;
        end
        check("postrst_grant_src0", src_ready, 2'b01);
        wait_quiet("postrst_done", 100);

        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/src_sink_arbiter.md
SRC_SINK_ARBITER -- requirements
Module: src_sink_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 2: number of source requesters, range 2..8.
REQ-002 SHALL have parameter DATA_W, default 8: beat width in bits.
REQ-003 SHALL have parameter BURST_MAX, default 4: maximum beats per grant, range 1..16.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: buffer entries, power of two, 2 or more.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: permits new grants.
REQ-008 SHALL have port src_valid, input, N_SRC bits: per-source beat valid.
REQ-009 SHALL have port src_data, input, N_SRC x DATA_W bits: per-source beat data.
REQ-010 SHALL have port src_ready, output, N_SRC bits: per-source beat accepted.
REQ-011 SHALL have port snk_valid, output, 1 bit: sink beat valid.
REQ-012 SHALL have port snk_data, output, DATA_W bits: sink beat data.
REQ-013 SHALL have port snk_src, output, clog2(N_SRC) bits: index of the source that produced snk_data.
REQ-014 SHALL have port snk_ready, input, 1 bit: sink accepts beat.
REQ-015 SHALL have port busy, output, 1 bit: high when state is not IDLE or the FIFO is not empty.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT and DRAIN.
REQ-017 IDLE: when enable is 1 and any src_valid is 1, SHALL select the first valid source at or after (last_grant+1) mod N_SRC, then enter GRANT next cycle.
REQ-018 GRANT: src_ready[g] SHALL be 1 only for the granted index g and only while the FIFO is not full; all other src_ready bits SHALL be 0.
REQ-019 A beat SHALL transfer when src_valid[g] and src_ready[g] are both 1; the beat pushes {g, src_data[g]} into the FIFO and increments the beat count.
REQ-020 GRANT SHALL end after the transfer that makes the beat count equal BURST_MAX, or on any cycle where src_valid[g] is 0. On ending, the block SHALL update last_grant to g, clear the beat count, and return to IDLE, or go to DRAIN if enable is 0.
REQ-021 When enable falls during GRANT, the in-flight cycle SHALL complete normally, then the FSM SHALL enter DRAIN with all src_ready held at 0.
REQ-022 DRAIN SHALL persist until the FIFO is empty, then go to IDLE.
REQ-023 snk_valid SHALL equal FIFO not-empty.
REQ-024 snk_data and snk_src SHALL be held stable while snk_valid is 1 and snk_ready is 0.
REQ-025 Latency: a beat accepted at edge t SHALL be visible on snk_data at edge t+1 if the FIFO was empty.
REQ-026 Push and pop in the same cycle SHALL be legal when the FIFO is not full; the occupancy then stays unchanged.
REQ-027 Push SHALL never occur when the FIFO is full, even if a pop occurs in the same cycle.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with a clog2(FIFO_DEPTH)+1 bit counter.
REQ-029 The order of beats at the sink SHALL equal their acceptance order.

Reset
REQ-030 While rst is 1, the block SHALL force: state IDLE, FIFO empty, beat count 0, last_grant = N_SRC-1 (so source 0 wins first).
REQ-031 While rst is 1, the outputs SHALL be: src_ready 0, snk_valid 0, snk_data 0, snk_src 0, busy 0.
REQ-032 Reset asserted mid-burst SHALL discard all buffered beats; no beat SHALL appear at the sink after rst deasserts unless it is newly accepted.

Structure
REQ-033 The package src_sink_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-034 The buffer SHALL be the sub-module src_sink_fifo (push/pop/full/empty, asynchronous active-high rst); the arbiter FSM and burst counter SHALL live in src_sink_arbiter.

Verification
REQ-035 Stimulus: enable=1, src0 streams 6 beats 0x10..0x15, snk_ready=1 -> sink receives 0x10..0x13 with snk_src=0, then a regrant to src0 delivers 0x14, 0x15.
REQ-036 Stimulus: both sources valid continuously -> grants alternate 0,1,0,1, with 4 beats each; first beat visible on the sink 1 cycle after its acceptance.
REQ-037 Stimulus: snk_ready=0 while src1 streams -> 4 beats accepted, src_ready drops to 0 on the full FIFO, snk_data held at the first beat; snk_ready=1 then drains in order.
REQ-038 Stimulus: enable driven 0 after 2 beats of src0 -> FSM goes GRANT->DRAIN, src_ready=0, busy stays 1 until both beats pop, then IDLE with busy=0.
REQ-039 Stimulus: rst pulsed with 3 beats buffered -> snk_valid=0 immediately, busy=0, and the next grant goes to src0.
